smss_sbox_lane_engine: RTL and testbench

- Multi-lane, lane-serial engine for the 6-bit SMSS power-map S-box.
- Accepts one N_LANES×6-bit word over a valid/ready handshake.
- Substitutes LPC lanes per cycle through one shared S-box datapath and returns the whole substituted word over a second valid/ready handshake.
- Generalises the fixed single-lane combinational S-box: lane count, lanes-per-cycle, both linear layers and the affine term are parameters.

---
 rtl/smss_sbox_lane_engine.sv | 152 +++++++++++++++
 tb/tb_smss_sbox_lane_engine.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/smss_sbox_lane_engine.sv
// Lane-serial SMSS 6-bit power-map S-box engine: LPC lanes per cycle, N_LANES/LPC cycles per word.
// Optional macro SMSS_LANE_PARITY_EN adds a registered per-lane parity output (out_par).
module smss_sbox_lane_engine #(
    parameter int          N_LANES  = 4,
    parameter int          LPC      = 1,
    parameter logic [35:0] ISO_M    = 36'h867D71243,
    parameter logic [35:0] INV_M    = 36'hC34203E75,
    parameter logic [5:0]  LIN_MASK = 6'h14,
    parameter logic [5:0]  LIN_VEC  = 6'h3F
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [6*N_LANES-1:0]   in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [6*N_LANES-1:0]   out_data
`ifdef SMSS_LANE_PARITY_EN
    ,
    output logic [N_LANES-1:0]     out_par
`endif
);

    localparam int LPC_SAFE = (LPC < 1) ? 1 : LPC;
    localparam int BEATS    = N_LANES / LPC_SAFE;
    localparam int BW       = (BEATS > 1) ? $clog2(BEATS) : 1;

    generate
        if ((LPC < 1) || ((N_LANES % LPC_SAFE) != 0)) begin : g_bad_cfg
            $error("smss_sbox_lane_engine: LPC must be >= 1 and divide N_LANES");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    function automatic logic [5:0] linmap(input logic [35:0] m, input logic [5:0] v);
        logic [5:0] r;
        r = '0;
        for (int i = 0; i < 6; i++) begin
            r[i] = ^(v & m[6*i +: 6]);
        end
        return r;
    endfunction

    function automatic logic [2:0] gmul(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] c;
        c[0] = (a[2] & b[2]) ^ (a[0] & b[1]) ^ (a[1] & b[0]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
        c[1] = (a[0] & b[0]) ^ (a[0] & b[2]) ^ (a[2] & b[0]) ^ (a[1] & b[2]) ^ (a[2] & b[1]);
        c[2] = (a[1] & b[1]) ^ (a[0] & b[1]) ^ (a[1] & b[0]) ^ (a[0] & b[2]) ^ (a[2] & b[0]);
        return c;
    endfunction

    function automatic logic [5:0] sbox(input logic [5:0] x);
        logic [5:0] z;
        logic [2:0] x0;
        logic [2:0] x1;
        logic [2:0] m;
        logic [2:0] u;
        logic [5:0] w;
        logic [5:0] p;
        z  = linmap(ISO_M, x);
        x0 = z[2:0];
        x1 = z[5:3];
        m  = gmul(x0, x1);
        // fourth power and square are bit rotations in this basis
        u  = {m[0], m[2], m[1]} ^ x0 ^ x1;
        w  = {gmul({x1[1], x1[0], x1[2]}, u), gmul({x0[1], x0[0], x0[2]}, u)};
        p  = linmap(INV_M, w);
        return (^(x & LIN_MASK)) ? (p ^ LIN_VEC) : p;
    endfunction

    state_t                 state_q, state_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [6*N_LANES-1:0]   src_q, src_d;
    logic [6*N_LANES-1:0]   res_q, res_d;
    logic [N_LANES-1:0]     par_q, par_d;
    logic [5:0]             sub;
    int                     lane;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            beat_q  <= '0;
            src_q   <= '0;
            res_q   <= '0;
            par_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            src_q   <= src_d;
            res_q   <= res_d;
            par_q   <= par_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        beat_d    = beat_q;
        src_d     = src_q;
        res_d     = res_q;
        par_d     = par_q;
        sub       = '0;
        lane      = 0;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state_q)
            IDLE: begin
                in_ready = ~rst;
                if (in_valid) begin
                    src_d   = in_data;
                    beat_d  = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                for (int j = 0; j < LPC_SAFE; j++) begin
                    lane                 = int'(beat_q) * LPC_SAFE + j;
                    sub                  = sbox(src_q[lane*6 +: 6]);
                    res_d[lane*6 +: 6]   = sub;
                    par_d[lane]          = ^sub;
                end
                beat_d = beat_q + 1'b1;
                if (beat_q == BW'(BEATS - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign out_data = res_q;

`ifdef SMSS_LANE_PARITY_EN
    assign out_par = par_q;
`else
    // parity register is kept but unobserved; it folds away in synthesis
    logic par_unused;
    assign par_unused = ^par_q;
`endif

endmodule

// File: tb/tb_smss_sbox_lane_engine.sv
// Scoreboard bench for smss_sbox_lane_engine: an LPC=1 and an LPC=4 instance share in_data.
module tb_smss_sbox_lane_engine;

    localparam logic [35:0] T_ISO = 36'h867D71243;
    localparam logic [35:0] T_INV = 36'hC34203E75;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [23:0] in_data = '0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1;
    logic [23:0] out_data;
    logic        in_valid4 = 1'b0, in_ready4, out_valid4;
    logic        out_ready4 = 1'b1;
    logic [23:0] out_data4;
`ifdef SMSS_LANE_PARITY_EN
    logic [3:0]  out_par, out_par4;
`endif

    always #5 clk = ~clk;

    smss_sbox_lane_engine #(.N_LANES(4), .LPC(1)) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
`ifdef SMSS_LANE_PARITY_EN
        , .out_par(out_par)
`endif
    );

    smss_sbox_lane_engine #(.N_LANES(4), .LPC(4)) u_dut4 (
        .clk(clk), .rst(rst), .in_valid(in_valid4), .in_ready(in_ready4), .in_data(in_data),
        .out_valid(out_valid4), .out_ready(out_ready4), .out_data(out_data4)
`ifdef SMSS_LANE_PARITY_EN
        , .out_par(out_par4)
`endif
    );

    int n_pass = 0;
    int n_total = 0;
    int cyc = 0;
    logic [23:0] exp_q[$];
    int          acc_q[$];
    logic [23:0] exp4_q[$];
    int          acc4_q[$];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic logic [5:0] tmap(input logic [35:0] m, input logic [5:0] v);
        logic [5:0] r = '0;
        for (int i = 0; i < 6; i++)
            for (int k = 0; k < 6; k++)
                if (m[6*i+k] && v[k]) r[i] = ~r[i];
        return r;
    endfunction

    function automatic logic [2:0] tmul(input logic [2:0] a, input logic [2:0] b);
        logic [2:0] c;
        c[0] = a[2]&b[2] ^ a[0]&b[1] ^ a[1]&b[0] ^ a[1]&b[2] ^ a[2]&b[1];
        c[1] = a[0]&b[0] ^ a[0]&b[2] ^ a[2]&b[0] ^ a[1]&b[2] ^ a[2]&b[1];
        c[2] = a[1]&b[1] ^ a[0]&b[1] ^ a[1]&b[0] ^ a[0]&b[2] ^ a[2]&b[0];
        return c;
    endfunction

    function automatic logic [5:0] gold(input logic [5:0] x);
        logic [5:0] z, w, p;
        logic [2:0] lo, hi, m, u, sq_lo, sq_hi;
        z     = tmap(T_ISO, x);
        lo    = z[2:0];
        hi    = z[5:3];
        m     = tmul(lo, hi);
        u     = {m[0], m[2], m[1]} ^ lo ^ hi;
        sq_lo = {lo[1], lo[0], lo[2]};
        sq_hi = {hi[1], hi[0], hi[2]};
        w     = {tmul(sq_hi, u), tmul(sq_lo, u)};
        p     = tmap(T_INV, w);
        if (x[4] ^ x[2]) p = p ^ 6'h3F;
        return p;
    endfunction

    function automatic logic [3:0] lane_par(input logic [23:0] d);
        logic [3:0] r;
        for (int k = 0; k < 4; k++) r[k] = ^d[6*k +: 6];
        return r;
    endfunction

    // Main monitor: data, latency, and hold-while-stalled checks
    logic        seen = 1'b0;
    logic        last_ordy = 1'b0;
    logic [23:0] held = '0;
    always @(negedge clk) begin
        if (rst) begin
            seen = 1'b0;
        end else if (out_valid) begin
            if (!seen) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_out", {40'd0, out_data}, 64'hDEAD);
                end else begin
                    logic [23:0] e;
                    int          a;
                    e = exp_q.pop_front();
                    a = acc_q.pop_front();
                    chk("out_data", {40'd0, out_data}, {40'd0, e});
                    chk("latency", 64'(cyc - a), 64'd4);
`ifdef SMSS_LANE_PARITY_EN
                    chk("out_par", {60'd0, out_par}, {60'd0, lane_par(e)});
`endif
                end
                held = out_data;
                seen = 1'b1;
            end else begin
                chk("hold_data", {40'd0, out_data}, {40'd0, held});
            end
        end else if (seen) begin
            chk("valid_dropped_without_ready", {63'd0, last_ordy}, 64'd1);
            seen = 1'b0;
        end
        last_ordy = out_ready;
    end

    logic seen4 = 1'b0;
    always @(negedge clk) begin
        if (rst || !out_valid4) begin
            seen4 = 1'b0;
        end else if (!seen4) begin
            seen4 = 1'b1;
            if (exp4_q.size() == 0) begin
                chk("unexpected_out4", {40'd0, out_data4}, 64'hDEAD);
            end else begin
                logic [23:0] e;
                int          a;
                e = exp4_q.pop_front();
                a = acc4_q.pop_front();
                chk("out_data_lpc4", {40'd0, out_data4}, {40'd0, e});
                chk("latency_lpc4", 64'(cyc - a), 64'd1);
            end
        end
    end

    task automatic send(input bit to4, input logic [23:0] d, input logic [23:0] e);
        in_data = d;
        if (to4) in_valid4 = 1'b1;
        else in_valid = 1'b1;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if ((to4 ? in_ready4 : in_ready) === 1'b1) begin
                if (to4) begin
                    exp4_q.push_back(e);
                    acc4_q.push_back(cyc + 1);
                end else begin
                    exp_q.push_back(e);
                    acc_q.push_back(cyc + 1);
                end
                @(posedge clk);
                #1;
                in_valid  = 1'b0;
                in_valid4 = 1'b0;
                return;
            end
        end
        chk("send_timeout", 64'd0, 64'd1);
        in_valid  = 1'b0;
        in_valid4 = 1'b0;
    endtask

    task automatic wait_out_valid();
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (out_valid === 1'b1) return;
        end
        chk("out_valid_timeout", 64'd0, 64'd1);
    endtask

    logic [23:0] pat_in, pat_out;

    initial begin
        pat_in  = {6'h14, 6'h04, 6'h00, 6'h04};
        pat_out = {6'h2B, 6'h0C, 6'h00, 6'h0C};

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("in_ready_in_reset", {63'd0, in_ready}, 64'd0);
        chk("out_valid_reset", {63'd0, out_valid}, 64'd0);
        chk("out_data_reset", {40'd0, out_data}, 64'd0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", {63'd0, in_ready}, 64'd1);

        @(posedge clk);
        #1;
        send(1'b0, 24'h000000, 24'h000000);
        @(negedge clk);
        chk("in_ready_run", {63'd0, in_ready}, 64'd0);
        repeat (6) @(posedge clk);
        #1;
        send(1'b0, pat_in, pat_out);
        repeat (6) @(posedge clk);
        #1;

        send(1'b1, 24'h000000, 24'h000000);
        send(1'b1, pat_in, pat_out);
        repeat (3) @(posedge clk);
        #1;

        // stall in DONE with stray in_valid pulses
        out_ready = 1'b0;
        send(1'b0, pat_in, pat_out);
        wait_out_valid();
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            in_valid = i[0];
            in_data  = 24'hFFFFFF ^ 24'(i);
            @(negedge clk);
            chk("in_ready_done", {63'd0, in_ready}, 64'd0);
            chk("out_valid_stall", {63'd0, out_valid}, 64'd1);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("in_ready_release", {63'd0, in_ready}, 64'd1);
        #1;

        // reset on the second RUN cycle discards the in-flight word
        @(posedge clk);
        #1;
        send(1'b0, pat_in, pat_out);
        @(posedge clk);
        #1 rst = 1'b1;
        void'(exp_q.pop_back());
        void'(acc_q.pop_back());
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("out_valid_midrun_rst", {63'd0, out_valid}, 64'd0);
        chk("out_data_midrun_rst", {40'd0, out_data}, 64'd0);
        chk("in_ready_midrun_rst", {63'd0, in_ready}, 64'd1);
        @(posedge clk);
        #1;
        send(1'b0, pat_in, pat_out);

        for (int v = 0; v < 64; v++) begin
            logic [5:0] x;
            x = 6'(v);
            send(1'b0, {18'd0, x}, {18'd0, gold(x)});
        end

        for (int i = 0; i < 200; i++) begin
            if (exp_q.size() == 0 && exp4_q.size() == 0) break;
            @(posedge clk);
        end
        chk("drain_pending", 64'(exp_q.size() + exp4_q.size()), 64'd0);
        @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

endmodule
